// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Runs a chain of N_STAGES processing stages one after another. Each stage is
// kicked with a one-cycle start pulse and then owns the shared memory port
// until it reports completion. Stages can be bypassed with a skip mask, and a
// per-stage timeout aborts the run if a stage hangs.
//
// Ports
//   clock          in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   en             in   start request, only looked at while idle
//   skip_mask      in   N_STAGES  bit i=1 bypasses stage i (latched on start)
//   timeout_limit  in   TMO_W     max WAIT cycles per stage, 0 = no timeout
//                                 (latched on start)
//   stage_start    out  N_STAGES  one-cycle start pulse for the granted stage
//   stage_done     in   N_STAGES  per-stage completion level
//   stage_addr     in   N_STAGES*ADDR_W  flattened, stage i at [i*ADDR_W +: ADDR_W]
//   stage_wr_en    in   N_STAGES  per-stage write enables
//   stage_wdata    in   N_STAGES*DATA_W  flattened like stage_addr
//   mem_addr       out  ADDR_W    granted stage's address (0 when no grant)
//   mem_wr_en      out  1         granted stage's write enable (0 when no grant)
//   mem_wdata      out  DATA_W    granted stage's write data (0 when no grant)
//   cur_stage      out  index of the granted stage
//   busy           out  high whenever the sequencer is not idle
//   done           out  one-cycle end-of-run pulse (normal or aborted)
//   err_timeout    out  sticky: last run was aborted by a timeout
//   err_stage      out  index of the stage that timed out
//   state_dbg      out  3   raw FSM state for debug / checker binding
//
// Stage handshake: the sequencer raises stage_start[i] for exactly one cycle
// and from the following cycle on samples stage_done[i] as a level every
// cycle; the first cycle it sees stage_done[i]=1 completes the stage. Only the
// granted stage's done bit is ever looked at, so a stage may leave its done
// level high after it has been released.
// -----------------------------------------------------------------------------
module stage_sequencer #(
  parameter int N_STAGES = 8,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 16,
  parameter int TMO_W    = 16
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         en,
  input  logic [N_STAGES-1:0]          skip_mask,
  input  logic [TMO_W-1:0]             timeout_limit,
  output logic [N_STAGES-1:0]          stage_start,
  input  logic [N_STAGES-1:0]          stage_done,
  input  logic [N_STAGES*ADDR_W-1:0]   stage_addr,
  input  logic [N_STAGES-1:0]          stage_wr_en,
  input  logic [N_STAGES*DATA_W-1:0]   stage_wdata,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_wr_en,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [$clog2(N_STAGES)-1:0]  cur_stage,
  output logic                         busy,
  output logic                         done,
  output logic                         err_timeout,
  output logic [$clog2(N_STAGES)-1:0]  err_stage,
  output logic [2:0]                   state_dbg
);

  localparam int IDX_W = $clog2(N_STAGES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t              state_q,       state_d;
  logic [IDX_W-1:0]    cur_stage_q,   cur_stage_d;
  logic [TMO_W-1:0]    timer_q,       timer_d;
  logic [N_STAGES-1:0] mask_q,        mask_d;
  logic [TMO_W-1:0]    limit_q,       limit_d;
  logic                err_timeout_q, err_timeout_d;
  logic [IDX_W-1:0]    err_stage_q,   err_stage_d;

  // Lowest non-skipped stage index >= floor_idx.
  // Result is {found, index}; index is meaningless when found=0.
  // floor_idx is one bit wider than an index so "past the last stage" fits.
  function automatic logic [IDX_W:0] find_free(
    input logic [N_STAGES-1:0] mask,
    input logic [IDX_W:0]      floor_idx
  );
    logic [IDX_W:0] res;
    res = '0;
    // Scanning downward lets the lowest qualifying index win.
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (!mask[i] && (i >= int'(floor_idx))) begin
        res = {1'b1, IDX_W'(i)};
      end
    end
    return res;
  endfunction

  logic [IDX_W:0]   first_pick;
  logic [IDX_W:0]   next_pick;
  logic [IDX_W:0]   next_floor;
  logic [TMO_W-1:0] timer_inc;
  logic             timeout_hit;
  logic             cur_done;
  logic             grant;

  // The first stage is chosen from the live mask because it is latched in
  // the very same cycle.
  assign first_pick = find_free(skip_mask, '0);
  assign next_floor = {1'b0, cur_stage_q} + (IDX_W + 1)'(1);
  assign next_pick  = find_free(mask_q, next_floor);

  // Saturating increment: the timer sticks at all-ones instead of wrapping,
  // so a disabled timeout can never alias back onto a small limit.
  assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + TMO_W'(1);
  // Comparing the incremented value means a limit of L allows exactly L
  // WAIT cycles before ERROR.
  assign timeout_hit = (limit_q != '0) && (timer_inc == limit_q);
  assign cur_done    = stage_done[cur_stage_q];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_stage_q   <= '0;
      timer_q       <= '0;
      mask_q        <= '0;
      limit_q       <= '0;
      err_timeout_q <= 1'b0;
      err_stage_q   <= '0;
    end else begin
      state_q       <= state_d;
      cur_stage_q   <= cur_stage_d;
      timer_q       <= timer_d;
      mask_q        <= mask_d;
      limit_q       <= limit_d;
      err_timeout_q <= err_timeout_d;
      err_stage_q   <= err_stage_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cur_stage_d   = cur_stage_q;
    timer_d       = timer_q;
    mask_d        = mask_q;
    limit_d       = limit_q;
    err_timeout_d = err_timeout_q;
    err_stage_d   = err_stage_q;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          mask_d        = skip_mask;
          limit_d       = timeout_limit;
          err_timeout_d = 1'b0;
          if (first_pick[IDX_W]) begin
            cur_stage_d = first_pick[IDX_W-1:0];
            state_d     = S_START;
          end else begin
            // Everything bypassed: the run is just the done pulse.
            state_d = S_FINISH;
          end
        end
      end

      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        timer_d = timer_inc;
        // Completion is checked first so it beats a coincident timeout.
        if (cur_done) begin
          state_d = S_NEXT;
        end else if (timeout_hit) begin
          // Flags are loaded on the way in so they are already valid while
          // the abort's done pulse is on the output.
          state_d       = S_ERROR;
          err_timeout_d = 1'b1;
          err_stage_d   = cur_stage_q;
        end
      end

      S_NEXT: begin
        if (next_pick[IDX_W]) begin
          cur_stage_d = next_pick[IDX_W-1:0];
          state_d     = S_START;
        end else begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: state_d = S_IDLE;
      S_ERROR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registered state, so reset forces them at once.
  // ---------------------------------------------------------------------------
  assign grant = (state_q == S_START) || (state_q == S_WAIT);

  always_comb begin
    stage_start = '0;
    if (state_q == S_START) begin
      stage_start = N_STAGES'(1) << cur_stage_q;
    end
  end

  // Memory port: only the granted stage is ever routed; everything else sees
  // a quiet bus, which keeps stray write enables off the shared memory.
  always_comb begin
    mem_addr  = '0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    if (grant) begin
      mem_addr  = stage_addr[int'(cur_stage_q) * ADDR_W +: ADDR_W];
      mem_wr_en = stage_wr_en[cur_stage_q];
      mem_wdata = stage_wdata[int'(cur_stage_q) * DATA_W +: DATA_W];
    end
  end

  assign cur_stage   = cur_stage_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH) || (state_q == S_ERROR);
  assign err_timeout = err_timeout_q;
  assign err_stage   = err_stage_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Bench for stage_sequencer (N_STAGES=8). For each run a reference model works
// out, from the skip mask, timeout limit and each stage's response delay, the
// cycle each stage starts, which stage owns the memory port in each cycle and
// the cycle of the done pulse. Stage responders are driven from that same
// schedule, and every cycle of the run is compared with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

  localparam int N  = 8;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int TW = 16;
  localparam int MAXC = 512;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic            clock;
  logic            rst;
  logic            en;
  logic [N-1:0]    skip_mask;
  logic [TW-1:0]   timeout_limit;
  logic [N-1:0]    stage_start;
  logic [N-1:0]    stage_done;
  logic [N*AW-1:0] stage_addr;
  logic [N-1:0]    stage_wr_en;
  logic [N*DW-1:0] stage_wdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_wr_en;
  logic [DW-1:0]   mem_wdata;
  logic [2:0]      cur_stage;
  logic            busy;
  logic            done;
  logic            err_timeout;
  logic [2:0]      err_stage;
  logic [2:0]      state_dbg;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  stage_sequencer #(
    .N_STAGES (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .TMO_W    (TW)
  ) dut (
    .clock         (clock),
    .rst           (rst),
    .en            (en),
    .skip_mask     (skip_mask),
    .timeout_limit (timeout_limit),
    .stage_start   (stage_start),
    .stage_done    (stage_done),
    .stage_addr    (stage_addr),
    .stage_wr_en   (stage_wr_en),
    .stage_wdata   (stage_wdata),
    .mem_addr      (mem_addr),
    .mem_wr_en     (mem_wr_en),
    .mem_wdata     (mem_wdata),
    .cur_stage     (cur_stage),
    .busy          (busy),
    .done          (done),
    .err_timeout   (err_timeout),
    .err_stage     (err_stage),
    .state_dbg     (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];   // stage indices expected to receive stage_start, in order

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: schedule of one run, cycle 0 = the accepting edge's cycle
  // ---------------------------------------------------------------------------
  int       dly[N];                // cycles from start to done level; 0 = never
  logic [N-1:0] m_start[MAXC];     // expected stage_start per cycle
  logic     m_gv[MAXC];            // some stage owns the memory port
  int       m_g[MAXC];             // which stage owns it
  logic [N-1:0] m_drv_done[MAXC];  // stage_done levels the responders drive
  int       m_end;                 // cycle carrying the done pulse
  logic     m_err;                 // expected err_timeout after the run
  int       m_err_stage;           // expected err_stage (sticky across runs)

  task automatic build_model(input logic [N-1:0] mask, input int limit);
    int t;
    bit timed;
    for (int c = 0; c < MAXC; c++) begin
      m_start[c]    = '0;
      m_gv[c]       = 1'b0;
      m_g[c]        = 0;
      m_drv_done[c] = '0;
    end
    exp_q.delete();
    t     = 1;
    timed = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!mask[i] && !timed) begin
        m_start[t][i] = 1'b1;
        exp_q.push_back(3'(i));
        if (dly[i] != 0) begin
          for (int c = t + dly[i]; c < MAXC; c++) m_drv_done[c][i] = 1'b1;
        end
        if (limit != 0 && (dly[i] == 0 || dly[i] > limit)) begin
          // limit WAIT cycles, then ERROR with its done pulse
          for (int c = t; c <= t + limit; c++) begin
            m_gv[c] = 1'b1;
            m_g[c]  = i;
          end
          m_end       = t + limit + 1;
          timed       = 1'b1;
          m_err       = 1'b1;
          m_err_stage = i;
        end else begin
          // START, dly WAIT cycles, NEXT
          for (int c = t; c <= t + dly[i]; c++) begin
            m_gv[c] = 1'b1;
            m_g[c]  = i;
          end
          t = t + dly[i] + 2;
        end
      end
    end
    if (!timed) m_end = t;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one run. Called at #1 after an edge with the DUT idle.
  // directed: fixed isolation patterns while stage 1 is granted.
  // abort_at: cycle at which rst is thrown mid-run (0 = never).
  // ---------------------------------------------------------------------------
  task automatic do_run(input string name, input logic [N-1:0] mask, input int limit,
                        input bit directed, input int abort_at);
    logic [N-1:0] noise;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic e_wr;
    bit aborted;
    build_model(mask, limit);
    aborted       = 1'b0;
    en            = 1'b1;
    skip_mask     = mask;
    timeout_limit = TW'(limit);
    stage_done    = '0;
    @(posedge clock); #1;
    for (int c = 1; c <= m_end + 1; c++) begin
      // Inputs that the DUT must ignore or mask are scrambled every cycle.
      en            = (c <= m_end) ? 1'($urandom_range(0, 1)) : 1'b0;
      skip_mask     = N'($urandom);
      timeout_limit = TW'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        stage_addr[i*AW +: AW]  = AW'($urandom);
        stage_wdata[i*DW +: DW] = DW'($urandom);
      end
      stage_wr_en = N'($urandom);
      noise       = N'($urandom);
      stage_done  = m_drv_done[c] | (noise & mask);
      if (directed && m_gv[c] && m_g[c] == 1) begin
        stage_done[6] = 1'b1;
        if (c[0]) begin
          stage_wr_en = 8'hFD;
        end else begin
          stage_wr_en[1]         = 1'b1;
          stage_addr[1*AW +: AW] = 11'h688;
          stage_wdata[1*DW +: DW] = 16'h1234;
        end
      end
      #1;
      check({name, ".stage_start"}, 32'(stage_start), 32'(m_start[c]));
      check({name, ".done"},        32'(done),        32'(c == m_end));
      check({name, ".busy"},        32'(busy),        32'(c <= m_end));
      if (c == 1) check({name, ".err_clr"}, 32'(err_timeout), 32'd0);
      if (stage_start != '0) begin
        if (exp_q.size() == 0) check({name, ".start_extra"}, 32'(stage_start), 32'd0);
        else check({name, ".start_order"}, 32'(stage_start), 32'(8'd1 << exp_q.pop_front()));
      end
      if (m_gv[c]) begin
        e_addr  = stage_addr[m_g[c]*AW +: AW];
        e_wdata = stage_wdata[m_g[c]*DW +: DW];
        e_wr    = stage_wr_en[m_g[c]];
        check({name, ".cur_stage"}, 32'(cur_stage), 32'(m_g[c]));
      end else begin
        e_addr  = '0;
        e_wdata = '0;
        e_wr    = 1'b0;
      end
      check({name, ".mem_addr"},  32'(mem_addr),  32'(e_addr));
      check({name, ".mem_wr_en"}, 32'(mem_wr_en), 32'(e_wr));
      check({name, ".mem_wdata"}, 32'(mem_wdata), 32'(e_wdata));
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check({name, ".rst_start"},  32'(stage_start), 32'd0);
        check({name, ".rst_busy"},   32'(busy),        32'd0);
        check({name, ".rst_done"},   32'(done),        32'd0);
        check({name, ".rst_cur"},    32'(cur_stage),   32'd0);
        check({name, ".rst_err"},    32'(err_timeout), 32'd0);
        check({name, ".rst_errstg"}, 32'(err_stage),   32'd0);
        check({name, ".rst_mem"},    32'({mem_addr, mem_wr_en, mem_wdata}), 32'd0);
        m_err       = 1'b0;
        m_err_stage = 0;
        exp_q.delete();
        aborted = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (aborted) begin
      en = 1'b0;
      repeat (2) begin
        @(posedge clock); #1;
        check({name, ".rst_hold_done"}, 32'(done), 32'd0);
      end
      rst = 1'b0;
      repeat (3) begin
        @(posedge clock); #1;
        check({name, ".post_rst_done"}, 32'(done), 32'd0);
        check({name, ".post_rst_busy"}, 32'(busy), 32'd0);
      end
    end else begin
      check({name, ".start_missing"}, 32'(exp_q.size()), 32'd0);
      check({name, ".err_timeout"},   32'(err_timeout),  32'(m_err));
      check({name, ".err_stage"},     32'(err_stage),    32'(m_err_stage));
      check({name, ".idle_busy"},     32'(busy),         32'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [N-1:0] rmask;
    int rlimit;
    rst           = 1'b1;
    en            = 1'b0;
    skip_mask     = '0;
    timeout_limit = '0;
    stage_done    = '0;
    stage_addr    = '0;
    stage_wr_en   = '0;
    stage_wdata   = '0;
    m_err_stage   = 0;
    #1;
    check("reset.busy",   32'(busy),        32'd0);
    check("reset.done",   32'(done),        32'd0);
    check("reset.start",  32'(stage_start), 32'd0);
    check("reset.cur",    32'(cur_stage),   32'd0);
    check("reset.err",    32'({err_timeout, err_stage}), 32'd0);
    check("reset.mem",    32'({mem_addr, mem_wr_en, mem_wdata}), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;
    @(posedge clock); #1;
    check("idle.busy", 32'(busy), 32'd0);

    // Full run: every stage answers 3 cycles after its start.
    for (int i = 0; i < N; i++) dly[i] = 3;
    do_run("full", 8'h00, 0, 1'b0, 0);

    // Skip run.
    for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 4);
    do_run("skip", 8'hA5, 0, 1'b0, 0);

    // All stages bypassed.
    do_run("allskip", 8'hFF, 0, 1'b0, 0);

    // Timeout on stage 2.
    for (int i = 0; i < N; i++) dly[i] = 3;
    dly[2] = 0;
    do_run("timeout", 8'h00, 4, 1'b0, 0);

    // Done and timeout in the same cycle: done wins.
    for (int i = 0; i < N; i++) dly[i] = 2;
    dly[3] = 5;
    do_run("tie", 8'h00, 5, 1'b0, 0);

    // Memory isolation around stage 1.
    for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 3);
    dly[1] = 6;
    do_run("isolate", 8'h00, 0, 1'b1, 0);

    // Timeout again so err_stage is non-zero, then reset in stage 4's WAIT.
    for (int i = 0; i < N; i++) dly[i] = 1;
    dly[5] = 0;
    do_run("timeout2", 8'h00, 2, 1'b0, 0);
    for (int i = 0; i < N; i++) dly[i] = 3;
    dly[4] = 10;
    do_run("abort", 8'h00, 0, 1'b0, 22);
    for (int i = 0; i < N; i++) dly[i] = 2;
    do_run("restart", 8'h00, 0, 1'b0, 0);

    // Randomized runs.
    for (int r = 0; r < 14; r++) begin
      rmask  = N'($urandom);
      rlimit = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        dly[i] = (rlimit == 0) ? $urandom_range(1, 7) : $urandom_range(0, 8);
      end
      do_run($sformatf("rand%0d", r), rmask, rlimit, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so a stuck run still ends with a report.
  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter N_STAGES, default 8: number of chained processing stages, range 2..16.
REQ-002 Parameter ADDR_W, default 11: shared memory address width.
REQ-003 Parameter DATA_W, default 16: shared memory data width.
REQ-004 Parameter TMO_W, default 16: timeout counter width.
REQ-005 Port clock, in, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst, in, 1: reset, asynchronous, active-high.
REQ-007 Port en, in, 1: start request, sampled only in IDLE.
REQ-008 Port skip_mask, in, N_STAGES: bit i=1 bypasses stage i; latched when en is accepted.
REQ-009 Port timeout_limit, in, TMO_W: maximum WAIT cycles per stage; 0 disables the timeout; latched when en is accepted.
REQ-010 Port stage_start, out, N_STAGES: one-cycle start pulse per stage.
REQ-011 Port stage_done, in, N_STAGES: per-stage completion; sampled as a level.
REQ-012 Port stage_addr, in, N_STAGES*ADDR_W: flattened stage addresses; stage i occupies bits [i*ADDR_W +: ADDR_W].
REQ-013 Port stage_wr_en, in, N_STAGES: per-stage write enables.
REQ-014 Port stage_wdata, in, N_STAGES*DATA_W: flattened stage write data, packed the same way as stage_addr.
REQ-015 Port mem_addr / mem_wr_en / mem_wdata, out, ADDR_W / 1 / DATA_W: the granted stage's memory signals, driven to the shared memory.
REQ-016 Port cur_stage, out, $clog2(N_STAGES): index of the granted stage.
REQ-017 Port busy, out, 1: high in every state except IDLE.
REQ-018 Port done, out, 1: one-cycle pulse marking the end of a run, normal or aborted.
REQ-019 Port err_timeout, out, 1: sticky flag set when a run is aborted by timeout.
REQ-020 Port err_stage, out, $clog2(N_STAGES): index of the stage that timed out.

Function
REQ-021 The FSM SHALL have the states IDLE, START, WAIT, NEXT, FINISH and ERROR, held in a registered state variable.
REQ-022 In IDLE with en=1, the block SHALL latch skip_mask and timeout_limit, clear err_timeout, and select the lowest non-skipped stage.
- Transition: to START, or to FINISH if all bits are skipped.
REQ-023 START SHALL last one cycle.
- stage_start[cur_stage]=1; all other bits 0.
- Timer cleared; then go to WAIT.
REQ-024 WAIT SHALL increment the timer every cycle.
- stage_done[cur_stage]=1: go to NEXT.
- Otherwise, timer==limit with limit!=0: go to ERROR.
- If done and timeout occur in the same cycle, done wins.
REQ-025 NEXT SHALL select the lowest non-skipped index greater than cur_stage.
- Found: go to START.
- None left: go to FINISH.
REQ-026 FINISH SHALL assert done for one cycle and then go to IDLE.
REQ-027 ERROR SHALL set err_timeout=1, load err_stage=cur_stage, assert done for one cycle, and then go to IDLE.
REQ-028 mem_* SHALL be a combinational mux of stage cur_stage during START and WAIT; in all other states mem_addr=0, mem_wr_en=0 and mem_wdata=0.
REQ-029 stage_wr_en of non-granted stages SHALL never reach mem_wr_en.
REQ-030 stage_done of non-granted stages SHALL be ignored.
REQ-031 en while busy=1 SHALL be ignored; it is not queued.
REQ-032 Timing SHALL be as follows:
- stage_start is high in the cycle after the edge that accepts en.
- Each stage costs START + WAIT(>=1) + NEXT.
- done is high two cycles after the edge that samples the final stage_done.
REQ-033 The timer SHALL saturate at its maximum value and never wrap.

Reset
REQ-034 While rst=1 (asynchronous), the outputs SHALL take these values:
- state=IDLE, cur_stage=0, timer=0, latched mask=0.
- stage_start=0, busy=0, done=0.
- err_timeout=0, err_stage=0.
- mem_addr=0, mem_wr_en=0, mem_wdata=0.
REQ-035 rst asserted mid-run SHALL abort the run immediately, without a done pulse; after deassertion the block SHALL wait in IDLE for a new en.

Verification
REQ-036 Full run, N=8, mask=0x00, limit=0, each stage raises done 3 cycles after its start:
- stage_start pulses stages 0..7 in order.
- done pulses once.
- Total latency 8*5+1 cycles from en.
REQ-037 Skip run, mask=0xA5:
- Only stages 1, 3, 4 and 6 receive stage_start.
- cur_stage never equals 0, 2, 5 or 7 while busy.
REQ-038 All-skip run, mask=0xFF:
- done pulses in the cycle after en is accepted.
- stage_start stays 0.
REQ-039 Timeout, limit=4, stage 2 never raises done:
- ERROR is entered after 4 WAIT cycles.
- err_timeout=1, err_stage=2, one done pulse.
- Stages 3..7 are never started.
REQ-040 Isolation:
- Stage 5 drives wr_en=1 while stage 1 is granted: mem_wr_en stays 0.
- Stage 1 drives wr_en=1, addr=0x688, data=0x1234: mem_* match exactly.
- A stray stage_done[6] while stage 1 is granted is ignored.
REQ-041 Reset mid-run:
- rst asserted while stage 4 is in WAIT: all outputs reach their reset values without a clock edge, and no done pulse occurs.
- A new en then starts again at stage 0.
